// File: rtl/mac_pkg.sv
// -----------------------------------------------------------------------------
// mac_pkg
// Shared definitions for the MAC-extension sequencer: operand/accumulator
// widths, command encodings, FSM state encoding and a small op-class helper.
// -----------------------------------------------------------------------------
package mac_pkg;

    localparam int MAC_XLEN   = 32;
    localparam int MAC_ACC_W  = 2 * MAC_XLEN;
    // One shift-add step per multiplier bit.
    localparam int MULT_STEPS = MAC_XLEN;

    typedef enum logic [1:0] {
        MAC_OP_MUL   = 2'b00,
        MAC_OP_MAC   = 2'b01,
        MAC_OP_CLR   = 2'b10,
        MAC_OP_RDACC = 2'b11
    } mac_op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_MULT = 3'd2,
        ST_ACC  = 3'd3,
        ST_RESP = 3'd4
    } mac_state_e;

    // MUL and MAC go through the multiplier; CLR and RDACC respond directly.
    function automatic logic is_mult_op(input mac_op_e op);
        return (op == MAC_OP_MUL) || (op == MAC_OP_MAC);
    endfunction

endpackage

// File: rtl/mac_operand_latch.sv
// -----------------------------------------------------------------------------
// mac_operand_latch
// Holds {multiplier, multiplicand} from the accepting edge of a MUL/MAC
// command until the next such command.
//
// Ports:
//   clock   - system clock, rising edge
//   reset   - asynchronous, active-high reset (clears the register)
//   i_load  - capture i_data on this rising edge
//   i_data  - {second_operand, first_operand}
//   o_data  - registered operand pair
// -----------------------------------------------------------------------------
module mac_operand_latch
    import mac_pkg::*;
#(
    parameter int W = 2 * MAC_XLEN
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data
);

    logic [W-1:0] r_data;

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_data;
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/mac_sequencer.sv
// -----------------------------------------------------------------------------
// mac_sequencer
// Multi-cycle unsigned multiply-accumulate controller. One command at a time:
// MUL/MAC run a fixed 32-step shift-add multiply (MAC also folds the product
// into a wrapping 64-bit accumulator); CLR and RDACC respond in one cycle.
//
// Ports:
//   clock, reset                 - clock (rising edge), async active-high reset
//   req_valid/req_ready          - command handshake (ready only in IDLE)
//   req_op                       - 00 MUL, 01 MAC, 10 CLR, 11 RDACC
//   first_operand/second_operand - multiplicand (rs1) / multiplier (rs2)
//   resp_valid/resp_ready        - result handshake
//   resp_data                    - result (product, accumulator or zero)
//   busy                         - high whenever the FSM is not in IDLE
//   acc_out                      - registered accumulator value
// -----------------------------------------------------------------------------
module mac_sequencer
    import mac_pkg::*;
#(
    parameter int XLEN  = MAC_XLEN,
    parameter int ACC_W = 2 * XLEN
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [XLEN-1:0]  first_operand,
    input  logic [XLEN-1:0]  second_operand,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [ACC_W-1:0] resp_data,
    output logic             busy,
    output logic [ACC_W-1:0] acc_out
);

    localparam int                CNT_W     = $clog2(XLEN);
    localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(XLEN - 1);

    mac_state_e       r_state;
    mac_op_e          r_op;
    logic [CNT_W-1:0] r_count;
    logic [ACC_W-1:0] r_product;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_resp_data;
    logic             r_req_ready;
    logic             r_resp_valid;
    logic             r_busy;

    logic             w_accept;
    mac_op_e          w_req_op;
    logic             w_load;
    logic [ACC_W-1:0] w_operands;
    logic [XLEN-1:0]  w_mcand;
    logic [XLEN-1:0]  w_mplier;
    logic [ACC_W-1:0] w_addend;

    assign w_req_op = mac_op_e'(req_op);
    // r_req_ready is high only in IDLE, so this also gates on the state.
    assign w_accept = req_valid && r_req_ready;
    assign w_load   = w_accept && is_mult_op(w_req_op);

    mac_operand_latch #(.W(ACC_W)) u_operand_latch (
        .clock  (clock),
        .reset  (reset),
        .i_load (w_load),
        .i_data ({second_operand, first_operand}),
        .o_data (w_operands)
    );

    assign w_mcand  = w_operands[XLEN-1:0];
    assign w_mplier = w_operands[ACC_W-1:XLEN];
    // Partial product for the current step: zero-extended multiplicand << i.
    assign w_addend = {{(ACC_W - XLEN){1'b0}}, w_mcand} << r_count;

    // FSM with registered handshake/status outputs. Reset aborts any
    // in-flight command and clears the accumulator.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_op         <= MAC_OP_MUL;
            r_count      <= '0;
            r_product    <= '0;
            r_acc        <= '0;
            r_resp_data  <= '0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op        <= w_req_op;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        case (w_req_op)
                            MAC_OP_MUL, MAC_OP_MAC: begin
                                r_product <= '0;
                                r_count   <= '0;
                                r_state   <= ST_LOAD;
                            end
                            MAC_OP_CLR: begin
                                r_acc        <= '0;
                                r_resp_data  <= '0;
                                r_resp_valid <= 1'b1;
                                r_state      <= ST_RESP;
                            end
                            default: begin // MAC_OP_RDACC
                                r_resp_data  <= r_acc;
                                r_resp_valid <= 1'b1;
                                r_state      <= ST_RESP;
                            end
                        endcase
                    end
                end
                ST_LOAD: begin
                    r_state <= ST_MULT;
                end
                ST_MULT: begin
                    if (w_mplier[r_count]) begin
                        r_product <= r_product + w_addend;
                    end
                    r_count <= r_count + CNT_W'(1);
                    if (r_count == LAST_STEP) begin
                        r_state <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    // Accumulator wraps modulo 2^ACC_W; the response is the
                    // product alone, not the new sum.
                    if (r_op == MAC_OP_MAC) begin
                        r_acc <= r_acc + r_product;
                    end
                    r_resp_data  <= r_product;
                    r_resp_valid <= 1'b1;
                    r_state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_busy       <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_req_ready  <= 1'b1;
                    r_resp_valid <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign busy       = r_busy;
    assign acc_out    = r_acc;

endmodule

// File: tb/tb_mac_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mac_sequencer
// Directed bench for mac_sequencer. Latency is counted in clock edges from the
// accepting edge (that edge counts as 1), so a MUL/MAC response is first seen
// at count 35 and CLR/RDACC at count 1.
// -----------------------------------------------------------------------------
module tb_mac_sequencer;
    import mac_pkg::*;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] first_operand;
    logic [31:0] second_operand;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_data;
    logic        busy;
    logic [63:0] acc_out;

    int checks   = 0;
    int failures = 0;

    localparam int MUL_LAT = MULT_STEPS + 3;

    mac_sequencer dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .first_operand  (first_operand),
        .second_operand (second_operand),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_data      (resp_data),
        .busy           (busy),
        .acc_out        (acc_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    // Issue one command from a negedge and wait (bounded) for resp_valid.
    // Returns at the negedge where resp_valid was first seen high.
    task automatic run_cmd(input mac_op_e op, input logic [31:0] a, input logic [31:0] b,
                           output logic [63:0] data, output int lat, output logic busy_ok);
        req_op         = op;
        first_operand  = a;
        second_operand = b;
        req_valid      = 1'b1;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        lat       = 1;
        busy_ok   = 1'b1;
        @(negedge clock);
        while (resp_valid !== 1'b1 && lat < 100) begin
            if (req_ready !== 1'b0 || busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clock);
            lat++;
            @(negedge clock);
        end
        data = resp_data;
    endtask

    // Let the response handshake happen (resp_ready high) and confirm IDLE.
    task automatic finish_resp(input string tag);
        @(posedge clock);
        @(negedge clock);
        check({tag, "_idle_valid"}, {63'd0, resp_valid}, 64'd0);
        check({tag, "_idle_ready"}, {63'd0, req_ready}, 64'd1);
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    logic [63:0] data;
    int          lat;
    logic        busy_ok;
    logic        flag_ok;

    initial begin
        reset          = 1'b1;
        req_valid      = 1'b0;
        req_op         = 2'b00;
        first_operand  = '0;
        second_operand = '0;
        resp_ready     = 1'b1;
        repeat (2) @(negedge clock);

        // Reset values
        check("rst_req_ready",  {63'd0, req_ready},  64'd1);
        check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        check("rst_resp_data",  resp_data,           64'd0);
        check("rst_busy",       {63'd0, busy},       64'd0);
        check("rst_acc_out",    acc_out,             64'd0);
        reset = 1'b0;
        @(negedge clock);

        // MUL 3 x 5
        run_cmd(MAC_OP_MUL, 32'd3, 32'd5, data, lat, busy_ok);
        check("mul3x5_data", data, 64'h0000_0000_0000_000F);
        check("mul3x5_lat",  64'(lat), 64'(MUL_LAT));
        check("mul3x5_busy_ready_low", {63'd0, busy_ok}, 64'd1);
        check("mul3x5_acc", acc_out, 64'd0);
        finish_resp("mul3x5");

        // Zero multiplicand
        run_cmd(MAC_OP_MUL, 32'd0, 32'hDEAD_BEEF, data, lat, busy_ok);
        check("mul0_data", data, 64'd0);
        check("mul0_lat",  64'(lat), 64'(MUL_LAT));
        finish_resp("mul0");

        // Backpressure: hold resp_ready low 5 cycles, pulse req_valid meanwhile
        resp_ready = 1'b0;
        run_cmd(MAC_OP_MUL, 32'h0001_0000, 32'h0001_0000, data, lat, busy_ok);
        check("bp_data", data, 64'h0000_0001_0000_0000);
        check("bp_lat",  64'(lat), 64'(MUL_LAT));
        flag_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            if (i == 1 || i == 3) begin
                req_valid      = 1'b1;
                req_op         = MAC_OP_MAC;
                first_operand  = 32'h0000_1234;
                second_operand = 32'h0000_5678;
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clock);
            if (resp_valid !== 1'b1 || resp_data !== 64'h0000_0001_0000_0000 ||
                req_ready !== 1'b0 || busy !== 1'b1) flag_ok = 1'b0;
        end
        req_valid = 1'b0;
        check("bp_held_stable", {63'd0, flag_ok}, 64'd1);
        resp_ready = 1'b1;
        finish_resp("bp");
        check("bp_acc_untouched", acc_out, 64'd0);

        // MAC 0xFFFFFFFF^2 twice from reset: accumulator wraps
        pulse_reset();
        run_cmd(MAC_OP_MAC, 32'hFFFF_FFFF, 32'hFFFF_FFFF, data, lat, busy_ok);
        check("mac1_data", data, 64'hFFFF_FFFE_0000_0001);
        check("mac1_acc",  acc_out, 64'hFFFF_FFFE_0000_0001);
        finish_resp("mac1");
        run_cmd(MAC_OP_MAC, 32'hFFFF_FFFF, 32'hFFFF_FFFF, data, lat, busy_ok);
        check("mac2_data", data, 64'hFFFF_FFFE_0000_0001);
        check("mac2_acc_wrap", acc_out, 64'hFFFF_FFFC_0000_0002);
        finish_resp("mac2");

        // CLR, then MAC 7 x 6, RDACC, CLR, RDACC
        run_cmd(MAC_OP_CLR, 32'd0, 32'd0, data, lat, busy_ok);
        check("clr0_data", data, 64'd0);
        check("clr0_acc",  acc_out, 64'd0);
        finish_resp("clr0");
        run_cmd(MAC_OP_MAC, 32'd7, 32'd6, data, lat, busy_ok);
        check("mac7x6_data", data, 64'h2A);
        check("mac7x6_acc",  acc_out, 64'h2A);
        finish_resp("mac7x6");
        run_cmd(MAC_OP_RDACC, 32'd0, 32'd0, data, lat, busy_ok);
        check("rd1_data", data, 64'h2A);
        check("rd1_lat",  64'(lat), 64'd1);
        finish_resp("rd1");
        run_cmd(MAC_OP_CLR, 32'd0, 32'd0, data, lat, busy_ok);
        check("clr1_data", data, 64'd0);
        check("clr1_lat",  64'(lat), 64'd1);
        check("clr1_acc",  acc_out, 64'd0);
        finish_resp("clr1");
        run_cmd(MAC_OP_RDACC, 32'd0, 32'd0, data, lat, busy_ok);
        check("rd2_data", data, 64'd0);
        check("rd2_lat",  64'(lat), 64'd1);
        finish_resp("rd2");

        // Rebuild acc = 0x2A, then reset in MULT cycle 10 of a MAC
        run_cmd(MAC_OP_MAC, 32'd7, 32'd6, data, lat, busy_ok);
        check("pre_abort_acc", acc_out, 64'h2A);
        finish_resp("pre_abort");
        req_op         = MAC_OP_MAC;
        first_operand  = 32'd9;
        second_operand = 32'd9;
        req_valid      = 1'b1;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        repeat (10) @(posedge clock);
        #2;
        check("abort_busy_before", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        #1;
        check("abort_req_ready",  {63'd0, req_ready},  64'd1);
        check("abort_resp_valid", {63'd0, resp_valid}, 64'd0);
        check("abort_resp_data",  resp_data,           64'd0);
        check("abort_busy",       {63'd0, busy},       64'd0);
        check("abort_acc_out",    acc_out,             64'd0);
        @(negedge clock);
        reset = 1'b0;
        flag_ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (resp_valid !== 1'b0 || busy !== 1'b0) flag_ok = 1'b0;
        end
        check("abort_no_resp", {63'd0, flag_ok}, 64'd1);

        run_cmd(MAC_OP_MUL, 32'd2, 32'd2, data, lat, busy_ok);
        check("mul2x2_data", data, 64'd4);
        check("mul2x2_lat",  64'(lat), 64'(MUL_LAT));
        check("mul2x2_acc",  acc_out, 64'd0);
        finish_resp("mul2x2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
